// File: rtl/controle_bloqueio_if.sv
// Verdict/unlock inputs and status outputs of the Polilock attempt-rate controller.
// The master drives verdicts and unlock; the slave (controller) drives status.
interface controle_bloqueio_if;
  logic       tentativa_ok;
  logic       tentativa_erro;
  logic       liberar;
  logic       pode_tentar;
  logic       bloqueado;
  logic       fim_bloqueio;
  logic [3:0] tentativas_restantes;
  logic [3:0] db_estado;
  logic [3:0] db_contagem;

  modport master (
    output tentativa_ok, tentativa_erro, liberar,
    input  pode_tentar, bloqueado, fim_bloqueio,
           tentativas_restantes, db_estado, db_contagem
  );

  modport slave (
    input  tentativa_ok, tentativa_erro, liberar,
    output pode_tentar, bloqueado, fim_bloqueio,
           tentativas_restantes, db_estado, db_contagem
  );
endinterface

// File: rtl/controle_bloqueio.sv
// Attempt-rate and lockout controller: cooldown after each wrong attempt,
// escalating timed lockout after MAX_TENTATIVAS consecutive failures.
module controle_bloqueio #(
  parameter int MAX_TENTATIVAS = 3,
  parameter int TEMPO_ESPERA   = 4,
  parameter int TEMPO_BLOQUEIO = 8,
  parameter int NIVEL_MAX      = 2
) (
  input logic                clock,
  input logic                reset,
  controle_bloqueio_if.slave bus
);

  localparam int NIVEL_W   = (NIVEL_MAX > 0) ? $clog2(NIVEL_MAX + 1) : 1;
  localparam int TIMER_W_B = $clog2((TEMPO_BLOQUEIO << NIVEL_MAX) + 1);
  localparam int TIMER_W_E = $clog2(TEMPO_ESPERA + 1);
  localparam int TIMER_W   = (TIMER_W_B > TIMER_W_E) ? TIMER_W_B : TIMER_W_E;

  typedef enum logic [1:0] {
    LIVRE    = 2'd0,
    ESPERA   = 2'd1,
    BLOQUEIO = 2'd2,
    LIBERA   = 2'd3
  } estado_t;

  estado_t              estado, estado_n;
  logic [3:0]           erros, erros_n;
  logic [NIVEL_W-1:0]   nivel, nivel_n;
  logic [TIMER_W-1:0]   timer, timer_n;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= LIVRE;
      erros  <= '0;
      nivel  <= '0;
      timer  <= '0;
    end else begin
      estado <= estado_n;
      erros  <= erros_n;
      nivel  <= nivel_n;
      timer  <= timer_n;
    end
  end

  // NOTE: every next-state variable is defaulted to its current value first,
  // so no path through the case leaves one unassigned and infers a latch.
  always_comb begin
    estado_n = estado;
    erros_n  = erros;
    nivel_n  = nivel;
    timer_n  = timer;

    if (bus.liberar) begin
      estado_n = LIVRE;
      erros_n  = '0;
      nivel_n  = '0;
      timer_n  = '0;
    end else begin
      unique case (estado)
        LIVRE: begin
          // ok wins over a simultaneous erro
          if (bus.tentativa_ok) begin
            erros_n = '0;
            nivel_n = '0;
          end else if (bus.tentativa_erro) begin
            if (int'(erros) + 1 < MAX_TENTATIVAS) begin
              erros_n  = erros + 4'd1;
              timer_n  = TIMER_W'(TEMPO_ESPERA - 1);
              estado_n = ESPERA;
            end else begin
              erros_n  = 4'(MAX_TENTATIVAS);
              timer_n  = TIMER_W'((TEMPO_BLOQUEIO << nivel) - 1);
              estado_n = BLOQUEIO;
            end
          end
        end
        ESPERA: begin
          if (timer == '0) estado_n = LIVRE;
          else             timer_n  = timer - 1'b1;
        end
        BLOQUEIO: begin
          if (timer == '0) begin
            estado_n = LIBERA;
            if (int'(nivel) < NIVEL_MAX) nivel_n = nivel + 1'b1;
          end else begin
            timer_n = timer - 1'b1;
          end
        end
        LIBERA: begin
          erros_n  = '0;
          estado_n = LIVRE;
        end
        default: estado_n = LIVRE;
      endcase
    end
  end

  // Moore outputs, decoded from registers only
  assign bus.pode_tentar          = (estado == LIVRE);
  assign bus.bloqueado            = (estado == BLOQUEIO);
  assign bus.fim_bloqueio         = (estado == LIBERA);
  assign bus.tentativas_restantes = 4'(MAX_TENTATIVAS) - erros;
  assign bus.db_estado            = {2'b00, estado};
  assign bus.db_contagem          = erros;

endmodule

// File: tb/tb_controle_bloqueio.sv
// Bench for controle_bloqueio: directed scenarios with literal expectations plus
// randomized traffic, all outputs compared every cycle against a phase/cycle model.
module tb_controle_bloqueio;

  localparam int MAXT = 3;
  localparam int TE   = 4;
  localparam int TB   = 8;
  localparam int NMAX = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  controle_bloqueio_if bus();

  controle_bloqueio #(
    .MAX_TENTATIVAS(MAXT), .TEMPO_ESPERA(TE),
    .TEMPO_BLOQUEIO(TB), .NIVEL_MAX(NMAX)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: which phase we are in and how many cycles of it remain.
  // mode 0 free, 1 cooldown, 2 lockout, 3 release pulse
  int m_mode = 0, m_left = 0, m_erros = 0, m_nivel = 0;

  // Last sampled DUT outputs
  int s_pode, s_bloq, s_fim, s_rest, s_estado, s_cont;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit lib, input bit ok, input bit erro);
    if (rst || lib) begin
      m_mode = 0; m_erros = 0; m_nivel = 0; m_left = 0;
    end else begin
      case (m_mode)
        0: if (ok) begin
             m_erros = 0; m_nivel = 0;
           end else if (erro) begin
             if (m_erros + 1 < MAXT) begin
               m_erros++; m_mode = 1; m_left = TE;
             end else begin
               m_erros = MAXT; m_mode = 2; m_left = TB * (2 ** m_nivel);
             end
           end
        1: begin
             m_left--;
             if (m_left == 0) m_mode = 0;
           end
        2: begin
             m_left--;
             if (m_left == 0) begin
               m_mode = 3;
               m_nivel = (m_nivel + 1 > NMAX) ? NMAX : m_nivel + 1;
             end
           end
        default: begin
             m_erros = 0; m_mode = 0;
           end
      endcase
    end
  endtask

  // One clock: sample and compare at negedge, drive inputs, advance model at posedge.
  task automatic cycle(input bit rst, input bit lib, input bit ok, input bit erro);
    @(negedge clock);
    s_pode   = int'(bus.pode_tentar);
    s_bloq   = int'(bus.bloqueado);
    s_fim    = int'(bus.fim_bloqueio);
    s_rest   = int'(bus.tentativas_restantes);
    s_estado = int'(bus.db_estado);
    s_cont   = int'(bus.db_contagem);
    check("pode_tentar",          s_pode,   int'(m_mode == 0));
    check("bloqueado",            s_bloq,   int'(m_mode == 2));
    check("fim_bloqueio",         s_fim,    int'(m_mode == 3));
    check("tentativas_restantes", s_rest,   MAXT - m_erros);
    check("db_estado",            s_estado, m_mode);
    check("db_contagem",          s_cont,   m_erros);
    reset              = rst;
    bus.liberar        = lib;
    bus.tentativa_ok   = ok;
    bus.tentativa_erro = erro;
    @(posedge clock);
    model_step(rst, lib, ok, erro);
  endtask

  // Idle until the sampled state code differs from 'code'; n = cycles spent in it.
  task automatic count_phase(input int code, output int n);
    bit done = 0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      cycle(0, 0, 0, 0);
      if (s_estado == code) n++;
      else begin done = 1; break; end
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL phase_timeout: state %0d still held after 200 cycles", code);
    end
  endtask

  // From LIVRE with erros=0: three errors, returns lockout length (ends on LIBERA sample).
  task automatic lockout(output int len);
    int n;
    for (int k = 0; k < MAXT - 1; k++) begin
      cycle(0, 0, 0, 1);
      count_phase(1, n);
    end
    cycle(0, 0, 0, 1);
    count_phase(2, len);
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("reset_pode", s_pode, 1);
    check("reset_rest", s_rest, MAXT);
    check("reset_estado", s_estado, 0);
  endtask

  initial begin
    int n, len;
    bus.tentativa_ok   = 1'b0;
    bus.tentativa_erro = 1'b0;
    bus.liberar        = 1'b0;
    reset              = 1'b1;
    repeat (2) @(posedge clock);
    model_step(1, 0, 0, 0);

    // Reset values and a single failure
    do_reset();
    check("reset_bloq", s_bloq, 0);
    check("reset_cont", s_cont, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    check("espera_rest", s_rest, 2);
    check("espera_pode", s_pode, 0);
    count_phase(1, n);
    check("espera_len", n + 1, 4);
    check("after_espera_pode", s_pode, 1);

    // Lockout and expiry
    do_reset();
    lockout(len);
    check("lockout_len_0", len, 8);
    check("libera_fim", s_fim, 1);
    check("libera_rest", s_rest, 0);
    cycle(0, 0, 0, 0);
    check("post_libera_rest", s_rest, 3);
    check("post_libera_fim", s_fim, 0);

    // Escalation and saturation, then ok clears the level
    do_reset();
    lockout(len); check("esc_len_1", len, 8);
    lockout(len); check("esc_len_2", len, 16);
    lockout(len); check("esc_len_3", len, 32);
    lockout(len); check("esc_len_4", len, 32);
    cycle(0, 0, 1, 0);
    lockout(len); check("esc_after_ok", len, 8);

    // Verdicts ignored during ESPERA
    do_reset();
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 1);
    check("ign_espera_cont", s_cont, 1);
    count_phase(1, n);
    check("ign_espera_len", n + 3, 4);

    // Verdicts ignored during BLOQUEIO (erros already 1 -> one more cooldown)
    cycle(0, 0, 0, 1);
    count_phase(1, n);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 1, 1);
    check("ign_bloq_cont", s_cont, 3);
    count_phase(2, n);
    check("ign_bloq_len", n + 3, 8);

    // Simultaneous verdicts with erros=2
    do_reset();
    cycle(0, 0, 0, 1); count_phase(1, n);
    cycle(0, 0, 0, 1); count_phase(1, n);
    check("simul_pre_cont", s_cont, 2);
    cycle(0, 0, 1, 1);
    cycle(0, 0, 0, 0);
    check("simul_cont", s_cont, 0);
    check("simul_estado", s_estado, 0);

    // Administrative unlock at cycle 3 of a level-1 lockout
    do_reset();
    lockout(len);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1); count_phase(1, n);
    cycle(0, 0, 0, 1); count_phase(1, n);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    check("lib_in_bloq", s_bloq, 1);
    cycle(0, 0, 0, 0);
    check("lib_estado", s_estado, 0);
    check("lib_bloq", s_bloq, 0);
    check("lib_fim", s_fim, 0);
    lockout(len);
    check("lib_next_len", len, 8);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      int r;
      bit rst, lib, ok, erro;
      r    = int'($urandom_range(0, 199));
      rst  = (r == 0);
      lib  = (r >= 1 && r < 4);
      ok   = ($urandom_range(0, 9) == 0);
      erro = ($urandom_range(0, 2) == 0);
      cycle(rst, lib, ok, erro);
    end
    cycle(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/controle_bloqueio.md
# controle_bloqueio

Attempt-rate and lockout controller for the Polilock. It sits beside `unidade_controle` and consumes that controller's per-attempt verdict pulses. It enforces a short cooldown after every wrong attempt and a timed lockout after `MAX_TENTATIVAS` consecutive failures. Lockout length doubles on each successive lockout, saturating at `NIVEL_MAX`. Its status outputs gate `iniciar` and drive the `db_bloqueado`, `db_estado` and `db_contagem` debug displays (the last two via `hexa7seg`).

## Interface
- `MAX_TENTATIVAS`, default 3: consecutive failures that trigger lockout; legal range 1..15.
- `TEMPO_ESPERA`, default 4: cooldown after a non-final failure, in cycles; must be ≥1.
- `TEMPO_BLOQUEIO`, default 8: base lockout length, in cycles; must be ≥1.
- `NIVEL_MAX`, default 2: maximum escalation level; lockout length = `TEMPO_BLOQUEIO << nivel`.
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `tentativa_ok` in 1: one-cycle pulse, attempt verified correct.
- `tentativa_erro` in 1: one-cycle pulse, attempt verified wrong.
- `liberar` in 1: administrative unlock, level-sampled each cycle.
- `pode_tentar` out 1: new attempt allowed.
- `bloqueado` out 1: lockout active.
- `fim_bloqueio` out 1: one-cycle pulse when a lockout expires.
- `tentativas_restantes` out 4: `MAX_TENTATIVAS − erros`.
- `db_estado` out 4: state code.
- `db_contagem` out 4: current `erros`.

## Operation
Internal registers:
- `erros`: 4 bits.
- `nivel`: `$clog2(NIVEL_MAX+1)` bits, minimum 1.
- `timer`: sized by `$clog2((TEMPO_BLOQUEIO<<NIVEL_MAX)+1)`. It counts down and is loaded with `duration−1`.

States and `db_estado` codes:
- `LIVRE` (0x0): `pode_tentar`=1.
  - `tentativa_ok` → `erros`=0, `nivel`=0; stay in `LIVRE`.
  - `tentativa_erro` with `erros+1 < MAX_TENTATIVAS` → `erros`+=1, `timer`=`TEMPO_ESPERA−1`, go to `ESPERA`.
  - `tentativa_erro` with `erros+1 == MAX_TENTATIVAS` → `erros`=`MAX_TENTATIVAS`, `timer`=`(TEMPO_BLOQUEIO<<nivel)−1`, go to `BLOQUEIO`.
- `ESPERA` (0x1): `pode_tentar`=0.
  - `timer`==0 → go to `LIVRE`; otherwise `timer`−=1.
  - Both verdict inputs are ignored.
- `BLOQUEIO` (0x2): `bloqueado`=1, `pode_tentar`=0.
  - `timer`==0 → go to `LIBERA`, `nivel` = min(`nivel`+1, `NIVEL_MAX`); otherwise `timer`−=1.
  - Verdict inputs are ignored.
- `LIBERA` (0x3): `fim_bloqueio`=1 for exactly this one cycle; `erros`=0; unconditionally go to `LIVRE`. `nivel` is retained.

Priority, highest first:
1. `reset`
2. `liberar`
3. `tentativa_ok`
4. `tentativa_erro`

Boundary and priority rules:
- `liberar` in any state → next state `LIVRE`, with `erros`=0, `nivel`=0, `timer`=0. No `fim_bloqueio` pulse.
- `tentativa_ok` and `tentativa_erro` asserted together in `LIVRE` → treated as ok only.
- `nivel` saturates at `NIVEL_MAX` and never wraps. It clears only on `tentativa_ok` in `LIVRE`, on `liberar`, or on `reset`.
- `MAX_TENTATIVAS`=1: the first error goes directly to `BLOQUEIO`; `ESPERA` is never entered.
- `tentativas_restantes` is never negative. It reads 0 in `BLOQUEIO`, and `MAX_TENTATIVAS` again from `LIVRE` onward after `LIBERA` (`erros` is 0 after the `LIBERA` edge).

## Timing
- Reset values: state `LIVRE`; `erros`=0, `nivel`=0, `timer`=0.
- Output values at reset: `pode_tentar`=1, `bloqueado`=0, `fim_bloqueio`=0, `tentativas_restantes`=`MAX_TENTATIVAS`, `db_estado`=0x0, `db_contagem`=0.
- All outputs are Moore, decoded from registers. There is no combinational path from any input to any output.
- A verdict pulse sampled at edge k changes the outputs from cycle k+1 onward.
- `ESPERA` lasts exactly `TEMPO_ESPERA` cycles.
- `BLOQUEIO` lasts exactly `TEMPO_BLOQUEIO<<nivel` cycles, using the `nivel` value at entry.
- `LIBERA` lasts exactly 1 cycle.
- `reset` or `liberar` mid-cooldown or mid-lockout takes effect at the next edge; the timer is abandoned.

## Test plan
All scenarios use the default parameters (`MAX_TENTATIVAS`=3, `TEMPO_ESPERA`=4, `TEMPO_BLOQUEIO`=8, `NIVEL_MAX`=2).

1. **Reset and single failure.** Apply reset, then one `tentativa_erro` pulse.
   - `db_estado`=1 for 4 cycles with `pode_tentar`=0, `tentativas_restantes`=2.
   - Then `LIVRE`, `pode_tentar`=1.
2. **Lockout and expiry.** Three errors, each issued while in `LIVRE`.
   - `bloqueado`=1 for 8 cycles, `tentativas_restantes`=0.
   - Then one `fim_bloqueio` pulse, then `tentativas_restantes`=3.
3. **Escalation and saturation.** Repeat the 3-error sequence four times.
   - Lockout lengths are 8, 16, 32, 32 cycles.
   - Then a `tentativa_ok` → the next lockout is 8 cycles.
4. **Verdicts ignored while not free.** Pulse `tentativa_erro` and `tentativa_ok` during `ESPERA` and during `BLOQUEIO`.
   - No change to `erros`, `timer` or state.
5. **Simultaneous verdicts.** Assert `tentativa_ok` and `tentativa_erro` in the same cycle in `LIVRE` with `erros`=2.
   - `erros`=0, state remains `LIVRE`.
6. **Administrative unlock.** Assert `liberar` at cycle 3 of a lockout.
   - Next cycle: `LIVRE`, `bloqueado`=0, no `fim_bloqueio` pulse, `nivel`=0.
   - A subsequent lockout lasts 8 cycles.
